clock_step_controller: RTL

//   Run/halt/single-step sequencer for the pipeline's divided clock. Owns the CLOCK_50 divide

---
 rtl/clock_step_controller_if.sv | 12 +
 rtl/clock_step_controller.sv | 123 ++++++++++++
 2 files changed

// File: rtl/clock_step_controller_if.sv
// Host-to-controller command port: op/arg qualified by a valid/ready handshake.
interface clock_step_controller_if #(
  parameter int STEP_W = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/clock_step_controller.sv
// Run/halt/single-step sequencer for the divided pipeline clock; tick is combinational from state.
// Commands complete on the accept edge; cmd_ready drops in STEP, under halt_req and in reset.
module clock_step_controller #(
  parameter int DIV_W       = 10,
  parameter int DIV_DEFAULT = 217,
  parameter int STEP_W      = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 halt_req,
  clock_step_controller_if.slave cmd,
  output logic                 tick,
  output logic                 slow_clk,
  output logic                 running,
  output logic [STEP_W-1:0]    steps_left,
  output logic                 step_done,
  output logic                 cmd_err
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

  localparam logic [1:0]       OP_HALT    = 2'b00;
  localparam logic [1:0]       OP_RUN     = 2'b01;
  localparam logic [1:0]       OP_STEP    = 2'b10;
  localparam logic [1:0]       OP_SET_DIV = 2'b11;
  localparam logic [DIV_W-1:0] LIMIT_RST  = DIV_W'(DIV_DEFAULT);

  state_t           state;
  logic [DIV_W-1:0] limit;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pending;
  logic             pending_vld;
  logic             at_limit;
  logic             accept;
  logic             go_halt;

  assign at_limit      = (state != S_HALT) && (cnt == limit);
  assign tick          = !reset && at_limit;
  assign cmd.cmd_ready = !reset && !halt_req && (state != S_STEP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign go_halt       = halt_req || (accept && cmd.cmd_op == OP_HALT);
  assign running       = (state != S_HALT);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_HALT;
      limit       <= LIMIT_RST;
      cnt         <= '0;
      pending     <= '0;
      pending_vld <= 1'b0;
      slow_clk    <= 1'b0;
      steps_left  <= '0;
      step_done   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      step_done <= 1'b0;
      cmd_err   <= 1'b0;

      // Divided-period bookkeeping; a pending limit only takes effect at a period boundary.
      if (at_limit) begin
        cnt      <= '0;
        slow_clk <= ~slow_clk;
        if (pending_vld) begin
          limit       <= pending;
          pending_vld <= 1'b0;
        end
        if (state == S_STEP) begin
          if (steps_left == STEP_W'(1)) begin
            state      <= S_HALT;
            steps_left <= '0;
            step_done  <= 1'b1;
          end else begin
            steps_left <= steps_left - STEP_W'(1);
          end
        end
      end else if (state != S_HALT) begin
        cnt <= cnt + DIV_W'(1);
      end

      if (accept) begin
        case (cmd.cmd_op)
          OP_RUN: begin
            if (state == S_HALT) begin
              state <= S_RUN;
              cnt   <= '0;
            end
          end
          OP_STEP: begin
            if (state == S_HALT && cmd.cmd_arg != '0) begin
              state      <= S_STEP;
              steps_left <= cmd.cmd_arg;
              cnt        <= '0;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          OP_SET_DIV: begin
            if (state == S_HALT) begin
              limit <= cmd.cmd_arg[DIV_W-1:0];
            end else begin
              pending     <= cmd.cmd_arg[DIV_W-1:0];
              pending_vld <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Halt wins over everything above, including a final STEP tick on the same edge.
      if (go_halt) begin
        state      <= S_HALT;
        cnt        <= '0;
        steps_left <= '0;
        step_done  <= 1'b0;
        if (pending_vld) begin
          limit       <= pending;
          pending_vld <= 1'b0;
        end
      end
    end
  end

endmodule
